fu_branch_resolve: RTL and testbench

//  Resolution end of the branch-prediction interface. Queues fetch-time predictions in order and

---
 rtl/fu_branch_resolve_pkg.sv | 28 ++
 rtl/fu_branch_resolve_inflight_fifo.sv | 61 ++++++
 rtl/fu_branch_resolve.sv | 139 +++++++++++++
 tb/tb_fu_branch_resolve.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_branch_resolve_pkg.sv
// ============================================================================
// Module : fu_branch_resolve_pkg
// Desc   : Shared types for the branch-resolution unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fu_branch_resolve_pkg;

  localparam int unsigned C_WORD_W     = 32;
  localparam int unsigned C_INSN_BYTES = 4;

  typedef logic [C_WORD_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  taken;
    word_t target;
  } bp_pred_t;

  typedef enum logic {
    BR_RUN   = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_t;

endpackage

`default_nettype wire

// File: rtl/fu_branch_resolve_inflight_fifo.sv
// ============================================================================
// Module : fu_branch_resolve_inflight_fifo
// Desc   : In-order sync FIFO of in-flight predictions with push/pop/clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fu_branch_resolve_inflight_fifo #(
  parameter int unsigned DATA_W = 65,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic              clear,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned C_AW = $clog2(DEPTH);
  localparam int unsigned C_PW = C_AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [C_PW-1:0]   r_wr_ptr;
  logic [C_PW-1:0]   r_rd_ptr;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                   (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign rd_data = r_mem[r_rd_ptr[C_AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push && !full) begin
      r_mem[r_wr_ptr[C_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        r_wr_ptr <= r_wr_ptr + C_PW'(1);
      end
      if (pop && !empty) begin
        r_rd_ptr <= r_rd_ptr + C_PW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fu_branch_resolve.sv
// ============================================================================
// Module : fu_branch_resolve
// Desc   : Compares queued fetch predictions against execute outcomes and
//          drives predictor update and front-end redirect/flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fu_branch_resolve
  import fu_branch_resolve_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [WORD_W-1:0] pred_pc,
  input  logic              pred_taken,
  input  logic [WORD_W-1:0] pred_target,
  input  logic              resolve_valid,
  input  logic [WORD_W-1:0] resolve_pc,
  input  logic              actual_taken,
  input  logic [WORD_W-1:0] actual_target,
  output logic              update_btb,
  output logic [WORD_W-1:0] update_pc,
  output logic              branch_outcome,
  output logic [WORD_W-1:0] branch_target,
  output logic              flush,
  output logic [WORD_W-1:0] redirect_pc,
  output logic              resolve_err,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic              taken;
    logic [WORD_W-1:0] target;
  } pred_t;

  localparam int unsigned C_ENTRY_W = $bits(pred_t);

  br_state_t          r_state;
  logic               r_ready_en;
  logic               w_full;
  logic               w_empty;
  logic [C_ENTRY_W-1:0] w_rd_data;
  pred_t              w_head;
  logic               w_run;
  logic               w_push;
  logic               w_res;
  logic               w_res_ok;
  logic               w_res_empty;
  logic               w_pc_mis;
  logic               w_mispred;
  logic               w_kill;
  logic               w_pop;
  logic [WORD_W-1:0]  w_redirect;

  assign w_head      = w_rd_data;
  assign w_run       = (r_state == BR_RUN);
  assign pred_ready  = r_ready_en && w_run && !w_full;
  assign w_push      = pred_valid && pred_ready;
  assign w_res       = resolve_valid && w_run;
  assign w_res_ok    = w_res && !w_empty;
  assign w_res_empty = w_res && w_empty;
  assign w_pc_mis    = w_res_ok && (resolve_pc != w_head.pc);
  assign w_mispred   = w_res_ok && ((w_head.taken != actual_taken) ||
                                    (actual_taken && (w_head.target != actual_target)));
  assign w_kill      = w_pc_mis || w_mispred;
  assign w_pop       = w_res_ok && !w_kill;
  assign w_redirect  = actual_taken ? actual_target
                                    : resolve_pc + WORD_W'(C_INSN_BYTES);

  // Clear wins over a same-cycle push, so a kill discards the younger entry too.
  fu_branch_resolve_inflight_fifo #(
    .DATA_W (C_ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .push    (w_push),
    .wr_data ({pred_pc, pred_taken, pred_target}),
    .pop     (w_pop),
    .clear   (w_kill),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state        <= BR_RUN;
      r_ready_en     <= 1'b0;
      update_btb     <= 1'b0;
      update_pc      <= '0;
      branch_outcome <= 1'b0;
      branch_target  <= '0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      resolve_err    <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      r_ready_en  <= 1'b1;
      update_btb  <= w_res_ok;
      flush       <= w_kill;
      resolve_err <= w_res_empty || w_pc_mis;

      if (w_res_ok) begin
        update_pc      <= resolve_pc;
        branch_outcome <= actual_taken;
        branch_target  <= actual_target;
      end
      if (w_kill) begin
        redirect_pc <= w_redirect;
      end

      if (w_res_ok && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (w_kill && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end

      case (r_state)
        BR_RUN:   r_state <= w_kill ? BR_FLUSH : BR_RUN;
        BR_FLUSH: r_state <= BR_RUN;
        default:  r_state <= BR_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fu_branch_resolve.sv
// ============================================================================
// Module : tb_fu_branch_resolve
// Desc   : Scoreboard bench for fu_branch_resolve with directed and random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fu_branch_resolve;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam bit [CNT_W-1:0] C_SAT = '1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        actual_taken;
  logic [31:0] actual_target;
  logic        update_btb;
  logic [31:0] update_pc;
  logic        branch_outcome;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        resolve_err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  fu_branch_resolve #(.WORD_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .actual_taken(actual_taken), .actual_target(actual_target),
    .update_btb(update_btb), .update_pc(update_pc), .branch_outcome(branch_outcome),
    .branch_target(branch_target), .flush(flush), .redirect_pc(redirect_pc),
    .resolve_err(resolve_err), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         upd;
    bit  [31:0] pc;
    bit         oc;
    bit  [31:0] tgt;
    bit         fl;
    bit  [31:0] rd;
    bit         err;
    bit  [CNT_W-1:0] bc;
    bit  [CNT_W-1:0] mc;
  } exp_t;

  typedef struct {
    bit [31:0] pc;
    bit        taken;
    bit [31:0] tgt;
  } pred_m_t;

  exp_t    expq[$];
  pred_m_t mq[$];
  int      checks = 0;
  int      errors = 0;
  bit      m_flush = 0;
  bit      m_ready_en = 0;
  bit [CNT_W-1:0] m_bc = '0;
  bit [CNT_W-1:0] m_mc = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST && (update_btb || flush || resolve_err)) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: upd=%0b flush=%0b err=%0b with nothing expected",
                   update_btb, flush, resolve_err);
        end else begin
          e = expq.pop_front();
          chk("update_btb",  64'(update_btb),  64'(e.upd));
          chk("flush",       64'(flush),       64'(e.fl));
          chk("resolve_err", 64'(resolve_err), 64'(e.err));
          chk("branch_cnt",  64'(branch_cnt),  64'(e.bc));
          chk("mispred_cnt", 64'(mispred_cnt), 64'(e.mc));
          if (e.upd) begin
            chk("update_pc",      64'(update_pc),      64'(e.pc));
            chk("branch_outcome", 64'(branch_outcome), 64'(e.oc));
            chk("branch_target",  64'(branch_target),  64'(e.tgt));
          end
          if (e.fl) chk("redirect_pc", 64'(redirect_pc), 64'(e.rd));
        end
      end
    end
  end

  // One clock of stimulus; called just after a rising edge. Updates the reference model.
  task automatic step(bit pv, bit [31:0] ppc, bit pt, bit [31:0] ptg,
                      bit rv, bit [31:0] rpc, bit at, bit [31:0] atg);
    bit      m_ready;
    bit      clr;
    bit      mis;
    bit      pcm;
    exp_t    e;
    pred_m_t h;
    m_ready = m_ready_en && !m_flush && (mq.size() < DEPTH);
    chk("pred_ready", 64'(pred_ready), 64'(m_ready));
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    resolve_valid = rv; resolve_pc = rpc; actual_taken = at; actual_target = atg;
    clr = 0;
    e = '{default: 0};
    if (rv && !m_flush) begin
      if (mq.size() == 0) begin
        e.err = 1;
      end else begin
        h   = mq[0];
        pcm = (rpc != h.pc);
        mis = (h.taken != at) || (at && (h.tgt != atg));
        e.upd = 1; e.pc = rpc; e.oc = at; e.tgt = atg;
        e.fl  = mis || pcm;
        e.err = pcm;
        e.rd  = at ? atg : rpc + 32'd4;
        if (m_bc != C_SAT) m_bc++;
        if (e.fl && m_mc != C_SAT) m_mc++;
        if (e.fl) clr = 1;
        else void'(mq.pop_front());
      end
      e.bc = m_bc;
      e.mc = m_mc;
      expq.push_back(e);
    end
    if (pv && m_ready) mq.push_back('{ppc, pt, ptg});
    if (clr) mq.delete();
    m_flush = clr;
    @(posedge CLK);
    #1;
    m_ready_en = 1;
  endtask

  task automatic push(bit [31:0] pc, bit t, bit [31:0] tg);
    step(1, pc, t, tg, 0, 0, 0, 0);
  endtask

  task automatic resolve(bit [31:0] pc, bit t, bit [31:0] tg);
    step(0, 0, 0, 0, 1, pc, t, tg);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_pred_ready"}, 64'(pred_ready), 64'(0));
    chk({tag, "_outputs"},
        64'({update_btb, branch_outcome, flush, resolve_err,
             |update_pc, |branch_target, |redirect_pc, |branch_cnt, |mispred_cnt}),
        64'(0));
  endtask

  initial begin
    bit [31:0] rpc;
    bit        at;
    bit [31:0] atg;
    nRST = 0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    resolve_valid = 0; resolve_pc = 0; actual_taken = 0; actual_target = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    nRST = 1;
    chk("ready_at_release", 64'(pred_ready), 64'(0));

    // Correct prediction
    push(32'h100, 1, 32'h80);
    resolve(32'h100, 1, 32'h80);
    idle(2);
    // Direction mispredict, then ready drops for the flush cycle
    push(32'h200, 0, 32'h0);
    resolve(32'h200, 1, 32'h40);
    push(32'h999, 0, 32'h0);
    idle(2);
    resolve(32'h0, 0, 32'h0);
    idle(2);
    // Predicted taken, actually not taken
    push(32'h300, 1, 32'h10);
    resolve(32'h300, 0, 32'h0);
    idle(2);
    // Fill to DEPTH, pop+push while full is blocked, then accepted
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i) * 4, 0, 32'h0);
    step(1, 32'h2000, 0, 0, 1, 32'h1000, 0, 0);
    push(32'h2000, 0, 32'h0);
    for (int i = 1; i < DEPTH; i++) resolve(32'h1000 + 32'(i) * 4, 0, 32'h0);
    resolve(32'h2000, 0, 32'h0);
    idle(2);
    // Empty-queue error, then PC mismatch
    resolve(32'h500, 0, 32'h0);
    push(32'h504, 0, 32'h0);
    resolve(32'h500, 0, 32'h0);
    idle(2);
    resolve(32'h504, 0, 32'h0);
    idle(2);
    // Wrap of the fall-through address
    push(32'hFFFF_FFFC, 1, 32'h1000);
    resolve(32'hFFFF_FFFC, 0, 32'h0);
    idle(3);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (mq.size() != 0 && $urandom_range(9) != 0) begin
        rpc = mq[0].pc;
        at  = ($urandom_range(3) != 0) ? mq[0].taken : !mq[0].taken;
        atg = ($urandom_range(3) != 0) ? mq[0].tgt : {$urandom_range(255), 2'b00};
      end else begin
        rpc = {$urandom_range(255), 2'b00};
        at  = 1'($urandom_range(1));
        atg = {$urandom_range(255), 2'b00};
      end
      step($urandom_range(9) < 6, {$urandom_range(255), 2'b00}, 1'($urandom_range(1)),
           {$urandom_range(255), 2'b00},
           $urandom_range(9) < 4, rpc, at, atg);
    end
    idle(3);
    chk("drained_expected", 64'(expq.size()), 64'(0));
    chk("final_branch_cnt", 64'(branch_cnt), 64'(m_bc));
    chk("final_mispred_cnt", 64'(mispred_cnt), 64'(m_mc));

    // Asynchronous reset with entries queued and a resolve in flight
    for (int i = 0; i < 4; i++) push(32'h700 + 32'(i) * 4, 0, 32'h0);
    idle(2);
    resolve_valid = 1; resolve_pc = 32'h700; actual_taken = 0; actual_target = 0;
    nRST = 0;
    #2;
    check_zero("async_reset");
    mq.delete();
    m_bc = '0; m_mc = '0; m_flush = 0; m_ready_en = 0;
    resolve_valid = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("held_reset");
    nRST = 1;
    resolve(32'h700, 0, 32'h0);
    idle(3);
    chk("post_reset_expected", 64'(expq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
